acm_init_sequencer: RTL and testbench

Boot-time Wishbone master that sits directly upstream of the ACM controller. After reset it walks a table of (address, data) pairs, writes each entry into the ACM through the controller's Wishbone slave port, optionally reads each one back for verification, and reports status. When the sequence finishes, it hands the ACM Wishbone port over to the system host master through a pass-through mux.

---
 rtl/acm_init_sequencer_pkg.sv | 26 ++
 rtl/acm_init_sequencer_if.sv | 16 +
 rtl/acm_init_rom.sv | 25 ++
 rtl/acm_init_sequencer.sv | 164 ++++++++++++++++
 tb/tb_acm_init_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/acm_init_sequencer_pkg.sv
// Shared constants for the ACM boot-time init sequencer: FSM encoding,
// table entry field positions and the early-terminator marker.
package acm_init_sequencer_pkg;

    typedef logic [15:0] wb_word_t;

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic [7:0]  TERMINATOR = 8'hFF;
    localparam logic [15:0] TERM_ENTRY = {TERMINATOR, 8'h00};

    function automatic logic is_term(input logic [7:0] entry_addr);
        return entry_addr == TERMINATOR;
    endfunction

endpackage

// File: rtl/acm_init_sequencer_if.sv
// Wishbone classic bus bundle used on both the host side and the ACM side.
// master drives the request fields, slave returns read data and ack.
interface acm_init_sequencer_if;
    import acm_init_sequencer_pkg::*;

    logic     cyc;
    logic     stb;
    logic     we;
    wb_word_t adr;
    wb_word_t dat_w;
    wb_word_t dat_r;
    logic     ack;

    modport master (output cyc, stb, we, adr, dat_w, input  dat_r, ack);
    modport slave  (input  cyc, stb, we, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/acm_init_rom.sv
// Init table ROM: entry = {acm_addr, acm_data}; unused slots hold the terminator.
// One-cycle registered read, no stall path.
module acm_init_rom
    import acm_init_sequencer_pkg::*;
#(
    parameter int TABLE_DEPTH = 16
) (
    input  logic        clk,
    input  logic [7:0]  addr,
    output logic [15:0] dat
);

    always_ff @(posedge clk) begin
        if ({24'd0, addr} >= 32'(TABLE_DEPTH)) begin
            dat <= TERM_ENTRY;
        end else begin
            case (addr)
                8'd0:    dat <= 16'h10A5;
                8'd1:    dat <= 16'h115A;
                default: dat <= TERM_ENTRY;
            endcase
        end
    end

endmodule

// File: rtl/acm_init_sequencer.sv
// Boot-time Wishbone master writing (and optionally verifying) the ACM init table, then muxing the host through.
// Per entry: 1 fetch + 1 idle + slave latency per access; host requests stall (no ack) until DONE.
module acm_init_sequencer
    import acm_init_sequencer_pkg::*;
#(
    parameter int TABLE_DEPTH = 16,
    parameter int VERIFY      = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        init_start_i,
    acm_init_sequencer_if.slave         wbs,
    acm_init_sequencer_if.master        wbm,
    output logic                        init_busy_o,
    output logic                        init_done_o,
    output logic                        init_err_o,
    output logic [7:0]                  err_index_o
);

    localparam logic [7:0] DEPTH_LAST   = 8'(TABLE_DEPTH - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [7:0]  index;
    logic [7:0]  tmo_cnt;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dat;

    logic        seq_cyc;
    logic        seq_stb;
    logic        seq_we;
    wb_word_t    seq_adr;
    wb_word_t    seq_dat;

    // While a bus access is in flight the ROM prefetches the following entry,
    // so NEXT can spot a terminator without an extra fetch cycle.
    assign rom_addr = (state == ST_WRITE || state == ST_READ) ? index + 8'd1 : index;

    acm_init_rom #(
        .TABLE_DEPTH (TABLE_DEPTH)
    ) u_rom (
        .clk  (wb_clk_i),
        .addr (rom_addr),
        .dat  (rom_dat)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_RESET;
            index       <= 8'd0;
            tmo_cnt     <= 8'd0;
            seq_cyc     <= 1'b0;
            seq_stb     <= 1'b0;
            seq_we      <= 1'b0;
            seq_adr     <= '0;
            seq_dat     <= '0;
            init_busy_o <= 1'b0;
            init_done_o <= 1'b0;
            init_err_o  <= 1'b0;
            err_index_o <= 8'd0;
        end else begin
            case (state)
                ST_RESET: begin
                    state       <= ST_FETCH;
                    index       <= 8'd0;
                    init_busy_o <= 1'b1;
                end

                ST_FETCH: state <= ST_WRITE;

                ST_WRITE, ST_READ: begin
                    if (!seq_cyc) begin
                        if (state == ST_WRITE && is_term(rom_dat[ADDR_MSB:ADDR_LSB])) begin
                            state       <= ST_DONE;
                            init_busy_o <= 1'b0;
                            init_done_o <= 1'b1;
                        end else begin
                            seq_cyc <= 1'b1;
                            seq_stb <= 1'b1;
                            seq_we  <= (state == ST_WRITE);
                            tmo_cnt <= 8'd0;
                            if (state == ST_WRITE) begin
                                seq_adr <= {8'h00, rom_dat[ADDR_MSB:ADDR_LSB]};
                                seq_dat <= {8'h00, rom_dat[DATA_MSB:DATA_LSB]};
                            end
                        end
                    end else if (wbm.ack) begin
                        seq_cyc <= 1'b0;
                        seq_stb <= 1'b0;
                        seq_we  <= 1'b0;
                        if (state == ST_WRITE) begin
                            state <= (VERIFY != 0) ? ST_READ : ST_NEXT;
                        end else begin
                            if (wbm.dat_r[7:0] != seq_dat[7:0]) begin
                                init_err_o <= 1'b1;
                                if (!init_err_o) err_index_o <= index;
                            end
                            state <= ST_NEXT;
                        end
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        // A dead slave aborts the whole table rather than skipping one entry.
                        seq_cyc     <= 1'b0;
                        seq_stb     <= 1'b0;
                        seq_we      <= 1'b0;
                        init_err_o  <= 1'b1;
                        if (!init_err_o) err_index_o <= index;
                        state       <= ST_DONE;
                        init_busy_o <= 1'b0;
                        init_done_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                ST_NEXT: begin
                    index <= index + 8'd1;
                    if (index == DEPTH_LAST || is_term(rom_dat[ADDR_MSB:ADDR_LSB])) begin
                        state       <= ST_DONE;
                        init_busy_o <= 1'b0;
                        init_done_o <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                    end
                end

                ST_DONE: begin
                    // A rerun must not yank the bus out from under an active host cycle.
                    if (init_start_i && !wbs.cyc) begin
                        state       <= ST_FETCH;
                        index       <= 8'd0;
                        init_err_o  <= 1'b0;
                        err_index_o <= 8'd0;
                        init_busy_o <= 1'b1;
                        init_done_o <= 1'b0;
                    end
                end

                default: state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        if (state == ST_DONE) begin
            wbm.cyc   = wbs.cyc;
            wbm.stb   = wbs.stb;
            wbm.we    = wbs.we;
            wbm.adr   = wbs.adr;
            wbm.dat_w = wbs.dat_w;
            wbs.dat_r = wbm.dat_r;
            wbs.ack   = wbm.ack;
        end else begin
            wbm.cyc   = seq_cyc;
            wbm.stb   = seq_stb;
            wbm.we    = seq_we;
            wbm.adr   = seq_adr;
            wbm.dat_w = seq_dat;
            wbs.dat_r = '0;
            wbs.ack   = 1'b0;
        end
    end

endmodule

// File: tb/tb_acm_init_sequencer.sv
// Directed bench for acm_init_sequencer against a small ACM slave model
// (fixed latency, optional readback corruption of 0x11, optional never-ack).
module tb_acm_init_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_start;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_idx;

    int checks   = 0;
    int failures = 0;

    acm_init_sequencer_if wbs_bus ();
    acm_init_sequencer_if wbm_bus ();

    acm_init_sequencer #(
        .TABLE_DEPTH (16),
        .VERIFY      (1),
        .TIMEOUT     (20)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .init_start_i (init_start),
        .wbs          (wbs_bus),
        .wbm          (wbm_bus),
        .init_busy_o  (busy),
        .init_done_o  (done),
        .init_err_o   (err),
        .err_index_o  (err_idx)
    );

    always #5 clk = ~clk;

    // ACM slave model: acks 5 cycles after seeing a request, logs {we, adr, data}.
    logic [7:0]  mem [0:255];
    logic [24:0] op_log [0:63];
    int          op_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          lat    = 0;
    bit          no_ack  = 1'b0;
    bit          corrupt = 1'b0;
    logic [7:0]  rd_byte;

    always @(posedge clk) begin
        if (rst) begin
            wbm_bus.ack <= 1'b0;
            lat         <= 0;
        end else if (wbm_bus.cyc && wbm_bus.stb && !wbm_bus.ack) begin
            if (lat == 4) begin
                lat <= 0;
                if (!no_ack) begin
                    wbm_bus.ack <= 1'b1;
                    if (wbm_bus.we) begin
                        mem[wbm_bus.adr[7:0]]  <= wbm_bus.dat_w[7:0];
                        wbm_bus.dat_r          <= 16'h0000;
                        op_log[op_cnt[5:0]]    <= {1'b1, wbm_bus.adr, wbm_bus.dat_w[7:0]};
                        wr_cnt                 <= wr_cnt + 1;
                    end else begin
                        rd_byte = (corrupt && wbm_bus.adr[7:0] == 8'h11) ? 8'h00 : mem[wbm_bus.adr[7:0]];
                        wbm_bus.dat_r          <= {8'h00, rd_byte};
                        op_log[op_cnt[5:0]]    <= {1'b0, wbm_bus.adr, rd_byte};
                        rd_cnt                 <= rd_cnt + 1;
                    end
                    op_cnt <= op_cnt + 1;
                end
            end else begin
                lat <= lat + 1;
            end
        end else begin
            wbm_bus.ack <= 1'b0;
            lat         <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    initial begin
        bit ok;
        int early_ack;
        int wb;
        int rb;
        int ob;
        int cyc_hi;
        int extra;

        rst           = 1'b1;
        init_start    = 1'b0;
        wbs_bus.cyc   = 1'b0;
        wbs_bus.stb   = 1'b0;
        wbs_bus.we    = 1'b0;
        wbs_bus.adr   = 16'h0000;
        wbs_bus.dat_w = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_cyc",    wbm_bus.cyc,   0);
        check("rst_stb",    wbm_bus.stb,   0);
        check("rst_we",     wbm_bus.we,    0);
        check("rst_adr",    wbm_bus.adr,   0);
        check("rst_dat",    wbm_bus.dat_w, 0);
        check("rst_hack",   wbs_bus.ack,   0);
        check("rst_hdat",   wbs_bus.dat_r, 0);
        check("rst_busy",   busy,          0);
        check("rst_done",   done,          0);
        check("rst_err",    err,           0);
        check("rst_erridx", err_idx,       0);

        // Host read of 0x0010 pending from the first cycle of the sequence.
        rst         = 1'b0;
        wbs_bus.cyc = 1'b1;
        wbs_bus.stb = 1'b1;
        wbs_bus.adr = 16'h0010;
        @(negedge clk);
        check("busy_rise", busy, 1);
        check("done_low",  done, 0);

        ok = 1'b0;
        early_ack = 0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (wbs_bus.ack) early_ack++;
            @(negedge clk);
        end
        check("seq1_done",  ok,        1);
        check("host_stall", early_ack, 0);
        check("seq1_busy",  busy,      0);
        check("seq1_err",   err,       0);
        check("seq1_wr",    wr_cnt,    2);
        check("seq1_rd",    rd_cnt,    2);
        check("seq1_op0",   op_log[0], {1'b1, 16'h0010, 8'hA5});
        check("seq1_op1",   op_log[1], {1'b0, 16'h0010, 8'hA5});
        check("seq1_op2",   op_log[2], {1'b1, 16'h0011, 8'h5A});
        check("seq1_op3",   op_log[3], {1'b0, 16'h0011, 8'h5A});

        // Start while the host holds cyc must be ignored.
        pulse_start();
        check("ign_done", done, 1);
        check("ign_busy", busy, 0);

        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wbs_bus.ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("host_ack",   ok,            1);
        check("host_rdata", wbs_bus.dat_r, 16'h00A5);
        wbs_bus.cyc = 1'b0;
        wbs_bus.stb = 1'b0;
        @(negedge clk);

        // Readback mismatch on entry 1: flagged, sequence still completes.
        corrupt = 1'b1;
        wb = wr_cnt;
        rb = rd_cnt;
        pulse_start();
        check("mm_busy", busy, 1);
        check("mm_done0", done, 0);
        wait_done(300, ok);
        check("mm_done",   ok,          1);
        check("mm_err",    err,         1);
        check("mm_erridx", err_idx,     1);
        check("mm_wr",     wr_cnt - wb, 2);
        check("mm_rd",     rd_cnt - rb, 2);

        // Restart from DONE clears the sticky error.
        corrupt = 1'b0;
        wb = wr_cnt;
        pulse_start();
        check("clr_err",    err,     0);
        check("clr_erridx", err_idx, 0);
        wait_done(300, ok);
        check("clr_done",   ok,          1);
        check("clr_err2",   err,         0);
        check("clr_wr",     wr_cnt - wb, 2);

        // Reset while entry 1 is being written.
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wbm_bus.cyc && wbm_bus.we && wbm_bus.adr == 16'h0011) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rw_found", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_cyc",  wbm_bus.cyc, 0);
        check("rw_busy0", busy,       0);
        ob = op_cnt;
        @(negedge clk);
        check("rw_busy1", busy, 1);
        wait_done(300, ok);
        check("rw_done",  ok,                 1);
        check("rw_first", op_log[ob[5:0]],    {1'b1, 16'h0010, 8'hA5});
        check("rw_err",   err,                0);

        // Slave never acks: abort after TIMEOUT cycles on entry 0.
        no_ack = 1'b1;
        wb = wr_cnt;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wbm_bus.cyc) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("tmo_cyc_seen", ok, 1);
        cyc_hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (!wbm_bus.cyc) break;
            cyc_hi++;
            @(negedge clk);
        end
        check("tmo_cycles", cyc_hi,  20);
        check("tmo_done",   done,    1);
        check("tmo_err",    err,     1);
        check("tmo_erridx", err_idx, 0);
        extra = 0;
        repeat (10) begin
            if (wbm_bus.cyc) extra++;
            @(negedge clk);
        end
        check("tmo_quiet", extra,       0);
        check("tmo_wr",    wr_cnt - wb, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
